// File: rtl/bb_pkg.sv
// Shared definitions for the per-game baseball scorer and the series tracker:
// game result encoding, series state encoding and scorer action codes.
package bb_pkg;

   localparam logic [1:0] RES_A_WIN   = 2'd0;
   localparam logic [1:0] RES_B_WIN   = 2'd1;
   localparam logic [1:0] RES_DRAW    = 2'd2;
   localparam logic [1:0] RES_ILLEGAL = 2'd3;

   typedef logic [1:0] series_state_t;

   localparam series_state_t IDLE  = 2'd0;
   localparam series_state_t ACCUM = 2'd1;
   localparam series_state_t DONE  = 2'd2;

   // Play-by-play action codes emitted to the per-game scorer.
   localparam logic [2:0] ACT_NONE       = 3'd0;
   localparam logic [2:0] ACT_BALL       = 3'd1;
   localparam logic [2:0] ACT_STRIKE     = 3'd2;
   localparam logic [2:0] ACT_FOUL       = 3'd3;
   localparam logic [2:0] ACT_HIT        = 3'd4;
   localparam logic [2:0] ACT_OUT        = 3'd5;
   localparam logic [2:0] ACT_RUN        = 3'd6;
   localparam logic [2:0] ACT_END_INNING = 3'd7;

endpackage

// File: rtl/bb_series_decide.sv
// Combinational series decision on the post-update counts.
// Optional run-differential tie-break at the game limit: BB_SERIES_RUNDIFF_EN.
module bb_series_decide
   import bb_pkg::*;
#(
   parameter int MAX_GAMES = 5
)
(
   input  logic [3:0]  wins_a,
   input  logic [3:0]  wins_b,
   input  logic [3:0]  draws,
   input  logic [3:0]  games_played,
   input  logic [11:0] total_a,
   input  logic [11:0] total_b,
   output logic        decided,
   output logic [1:0]  verdict
);

   logic [5:0] remaining;
   logic [5:0] wa;
   logic [5:0] wb;

   // A side has clinched once its lead exceeds the games still to play.
   always_comb begin
      remaining = 6'(MAX_GAMES) - {2'b00, games_played};
      wa        = {2'b00, wins_a};
      wb        = {2'b00, wins_b};
      decided   = 1'b0;
      verdict   = RES_A_WIN;
      if (wa > wb + remaining) begin
         decided = 1'b1;
         verdict = RES_A_WIN;
      end else if (wb > wa + remaining) begin
         decided = 1'b1;
         verdict = RES_B_WIN;
      end else if (remaining == 6'd0) begin
         decided = 1'b1;
`ifdef BB_SERIES_RUNDIFF_EN
         if (total_a > total_b) begin
            verdict = RES_A_WIN;
         end else if (total_b > total_a) begin
            verdict = RES_B_WIN;
         end else begin
            verdict = RES_DRAW;
         end
`else
         verdict = RES_DRAW;
`endif
      end
   end

`ifdef BB_SERIES_RUNDIFF_EN
   logic unused_draws;
   assign unused_draws = ^draws;
`else
   logic unused_inputs;
   assign unused_inputs = ^{draws, total_a, total_b};
`endif

endmodule

// File: rtl/bb_series_tracker.sv
// Best-of-N series tracker fed by end-of-game records from the per-game scorer.
// Build option BB_SERIES_RUNDIFF_EN enables the run-differential tie-break.
module bb_series_tracker
   import bb_pkg::*;
#(
   parameter int MAX_GAMES = 5
)
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        game_valid,
   input  logic [7:0]  game_score_a,
   input  logic [7:0]  game_score_b,
   input  logic [1:0]  game_result,
   input  logic        series_clr,
   output logic        out_valid,
   output logic [1:0]  series_result,
   output logic [3:0]  wins_a,
   output logic [3:0]  wins_b,
   output logic [3:0]  draws,
   output logic [3:0]  games_played,
   output logic [11:0] total_a,
   output logic [11:0] total_b,
   output logic        err
);

   series_state_t state;

   logic        accept;
   logic        flag_err;
   logic [3:0]  next_wins_a;
   logic [3:0]  next_wins_b;
   logic [3:0]  next_draws;
   logic [3:0]  next_games_played;
   logic [11:0] next_total_a;
   logic [11:0] next_total_b;
   logic        decided;
   logic [1:0]  verdict;

   // A clear in the same cycle drops the game entirely, including its error.
   always_comb begin
      accept   = game_valid && !series_clr && (state != DONE) &&
                 (game_result != RES_ILLEGAL);
      flag_err = game_valid && !series_clr &&
                 ((state == DONE) || (game_result == RES_ILLEGAL));
      next_wins_a       = wins_a;
      next_wins_b       = wins_b;
      next_draws        = draws;
      next_games_played = games_played;
      next_total_a      = total_a;
      next_total_b      = total_b;
      if (accept) begin
         next_games_played = games_played + 4'd1;
         next_total_a      = total_a + {4'd0, game_score_a};
         next_total_b      = total_b + {4'd0, game_score_b};
         case (game_result)
            RES_A_WIN: next_wins_a = wins_a + 4'd1;
            RES_B_WIN: next_wins_b = wins_b + 4'd1;
            default:   next_draws  = draws + 4'd1;
         endcase
      end
   end

   bb_series_decide #(
      .MAX_GAMES (MAX_GAMES)
   ) u_decide (
      .wins_a       (next_wins_a),
      .wins_b       (next_wins_b),
      .draws        (next_draws),
      .games_played (next_games_played),
      .total_a      (next_total_a),
      .total_b      (next_total_b),
      .decided      (decided),
      .verdict      (verdict)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         out_valid     <= 1'b0;
         series_result <= RES_A_WIN;
         wins_a        <= 4'd0;
         wins_b        <= 4'd0;
         draws         <= 4'd0;
         games_played  <= 4'd0;
         total_a       <= 12'd0;
         total_b       <= 12'd0;
         err           <= 1'b0;
      end else begin
         out_valid     <= 1'b0;
         series_result <= RES_A_WIN;
         if (series_clr) begin
            state        <= IDLE;
            wins_a       <= 4'd0;
            wins_b       <= 4'd0;
            draws        <= 4'd0;
            games_played <= 4'd0;
            total_a      <= 12'd0;
            total_b      <= 12'd0;
            err          <= 1'b0;
         end else begin
            if (flag_err) begin
               err <= 1'b1;
            end
            if (accept) begin
               wins_a       <= next_wins_a;
               wins_b       <= next_wins_b;
               draws        <= next_draws;
               games_played <= next_games_played;
               total_a      <= next_total_a;
               total_b      <= next_total_b;
               if (decided) begin
                  state         <= DONE;
                  out_valid     <= 1'b1;
                  series_result <= verdict;
               end else begin
                  state <= ACCUM;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_bb_series_tracker.sv
// Self-checking bench for bb_series_tracker: directed series scenarios plus
// randomized games, compared against a behavioural series model.
module tb_bb_series_tracker;

   localparam int MAX_GAMES = 5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        game_valid = 1'b0;
   logic [7:0]  game_score_a = 8'd0;
   logic [7:0]  game_score_b = 8'd0;
   logic [1:0]  game_result = 2'd0;
   logic        series_clr = 1'b0;
   logic        out_valid;
   logic [1:0]  series_result;
   logic [3:0]  wins_a;
   logic [3:0]  wins_b;
   logic [3:0]  draws;
   logic [3:0]  games_played;
   logic [11:0] total_a;
   logic [11:0] total_b;
   logic        err;

   int checks = 0;
   int errors = 0;

   // Behavioural model of the series
   int m_wa, m_wb, m_dr, m_gp, m_ta, m_tb;
   bit m_err, m_done;
   bit exp_ov;
   int exp_res;

   always #5 clk = ~clk;

   bb_series_tracker #(
      .MAX_GAMES (MAX_GAMES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .game_valid    (game_valid),
      .game_score_a  (game_score_a),
      .game_score_b  (game_score_b),
      .game_result   (game_result),
      .series_clr    (series_clr),
      .out_valid     (out_valid),
      .series_result (series_result),
      .wins_a        (wins_a),
      .wins_b        (wins_b),
      .draws         (draws),
      .games_played  (games_played),
      .total_a       (total_a),
      .total_b       (total_b),
      .err           (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_wa = 0; m_wb = 0; m_dr = 0; m_gp = 0; m_ta = 0; m_tb = 0;
      m_err = 1'b0; m_done = 1'b0; exp_ov = 1'b0; exp_res = 0;
   endtask

   // Series is over once the trailing side cannot catch up in the games left.
   function automatic void judge(output bit dec, output int res);
      int left;
      left = MAX_GAMES - m_gp;
      dec  = 1'b1;
      res  = 2;
      if (m_wa - m_wb > left) res = 0;
      else if (m_wb - m_wa > left) res = 1;
      else if (left == 0) begin
`ifdef BB_SERIES_RUNDIFF_EN
         res = (m_ta > m_tb) ? 0 : ((m_tb > m_ta) ? 1 : 2);
`else
         res = 2;
`endif
      end else dec = 1'b0;
   endfunction

   task automatic model_clock(input bit v, input int r, input int sa, input int sb, input bit clr);
      bit dec;
      int res;
      exp_ov  = 1'b0;
      exp_res = 0;
      if (clr) begin
         model_reset();
      end else if (v) begin
         if (m_done || r == 3) begin
            m_err = 1'b1;
         end else begin
            if (r == 0) m_wa++;
            else if (r == 1) m_wb++;
            else m_dr++;
            m_gp++;
            m_ta += sa;
            m_tb += sb;
            judge(dec, res);
            if (dec) begin
               m_done  = 1'b1;
               exp_ov  = 1'b1;
               exp_res = res;
            end
         end
      end
   endtask

   task automatic check_all(input string lbl);
      check({lbl, ".out_valid"},     out_valid,     exp_ov);
      check({lbl, ".series_result"}, series_result, exp_res);
      check({lbl, ".wins_a"},        wins_a,        m_wa);
      check({lbl, ".wins_b"},        wins_b,        m_wb);
      check({lbl, ".draws"},         draws,         m_dr);
      check({lbl, ".games_played"},  games_played,  m_gp);
      check({lbl, ".total_a"},       total_a,       m_ta);
      check({lbl, ".total_b"},       total_b,       m_tb);
      check({lbl, ".err"},           err,           m_err);
   endtask

   // Called at a falling edge; drives one cycle of inputs and checks the result.
   task automatic step(input string lbl, input bit v, input int r, input int sa, input int sb, input bit clr);
      game_valid   = v;
      game_result  = r[1:0];
      game_score_a = sa[7:0];
      game_score_b = sb[7:0];
      series_clr   = clr;
      @(posedge clk);
      model_clock(v, r, sa, sb, clr);
      @(negedge clk);
      check_all(lbl);
   endtask

   task automatic idle(input string lbl);
      step(lbl, 1'b0, 0, 0, 0, 1'b0);
   endtask

   task automatic pulse_reset(input string lbl);
      game_valid = 1'b0;
      series_clr = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(lbl);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int r, sa, sb;
      bit v, clr;
      model_reset();

      $display("[TB] reset");
      @(negedge clk);
      @(negedge clk);
      check_all("reset");
      rst_n = 1'b1;
      idle("post_reset");

      $display("[TB] three straight A wins");
      step("t1_g1", 1'b1, 0, 3, 1, 1'b0);
      step("t1_g2", 1'b1, 0, 4, 2, 1'b0);
      step("t1_g3", 1'b1, 0, 5, 0, 1'b0);
      check("t1_out_valid", out_valid, 1);
      check("t1_result", series_result, 0);
      check("t1_wins_a", wins_a, 3);
      check("t1_games", games_played, 3);
      idle("t1_after");
      check("t1_pulse_end", out_valid, 0);
      step("t1_clr", 1'b0, 0, 0, 0, 1'b1);

      $display("[TB] B clinches with draws");
      step("t2_g1", 1'b1, 1, 2, 5, 1'b0);
      step("t2_g2", 1'b1, 2, 3, 3, 1'b0);
      step("t2_g3", 1'b1, 1, 1, 4, 1'b0);
      check("t2_no_verdict_yet", out_valid, 0);
      step("t2_g4", 1'b1, 2, 0, 0, 1'b0);
      check("t2_out_valid", out_valid, 1);
      check("t2_result", series_result, 1);
      check("t2_wins_b", wins_b, 2);
      check("t2_draws", draws, 2);
      step("t2_g5_late", 1'b1, 0, 6, 1, 1'b0);
      check("t2_late_err", err, 1);
      check("t2_frozen_total_a", total_a, 6);
      step("t2_clr", 1'b0, 0, 0, 0, 1'b1);

      $display("[TB] tie at game limit");
      step("t3_g1", 1'b1, 0, 2, 1, 1'b0);
      step("t3_g2", 1'b1, 1, 0, 7, 1'b0);
      step("t3_g3", 1'b1, 2, 4, 4, 1'b0);
      step("t3_g4", 1'b1, 2, 3, 3, 1'b0);
      step("t3_g5", 1'b1, 2, 5, 5, 1'b0);
      check("t3_out_valid", out_valid, 1);
      check("t3_total_a", total_a, 14);
      check("t3_total_b", total_b, 20);
`ifdef BB_SERIES_RUNDIFF_EN
      check("t3_result", series_result, 1);
`else
      check("t3_result", series_result, 2);
`endif
      step("t3_clr", 1'b0, 0, 0, 0, 1'b1);
      check("t3_clr_err", err, 0);

      $display("[TB] illegal game mid-series");
      step("t4_g1", 1'b1, 0, 1, 0, 1'b0);
      step("t4_bad", 1'b1, 3, 9, 9, 1'b0);
      check("t4_err", err, 1);
      check("t4_games", games_played, 1);
      step("t4_g2", 1'b1, 1, 2, 4, 1'b0);
      check("t4_games_after", games_played, 2);
      step("t4_clr", 1'b0, 0, 0, 0, 1'b1);

      $display("[TB] game after verdict, then clear with game");
      step("t5_g1", 1'b1, 1, 0, 1, 1'b0);
      step("t5_g2", 1'b1, 1, 0, 2, 1'b0);
      step("t5_g3", 1'b1, 1, 0, 3, 1'b0);
      step("t5_late", 1'b1, 0, 9, 0, 1'b0);
      check("t5_late_err", err, 1);
      check("t5_frozen_wins_a", wins_a, 0);
      step("t5_clr_game", 1'b1, 0, 7, 7, 1'b1);
      check("t5_clr_games", games_played, 0);
      check("t5_clr_out_valid", out_valid, 0);
      step("t5_idle_accepts", 1'b1, 0, 1, 1, 1'b0);
      check("t5_idle_games", games_played, 1);
      step("t5_clr2", 1'b0, 0, 0, 0, 1'b1);

      $display("[TB] async reset mid-series");
      step("t6_g1", 1'b1, 0, 2, 2, 1'b0);
      step("t6_g2", 1'b1, 1, 3, 3, 1'b0);
      pulse_reset("t6_rst");
      check("t6_rst_games", games_played, 0);
      step("t6_a1", 1'b1, 0, 1, 0, 1'b0);
      step("t6_a2", 1'b1, 0, 1, 0, 1'b0);
      step("t6_a3", 1'b1, 0, 1, 0, 1'b0);
      check("t6_out_valid", out_valid, 1);
      check("t6_result", series_result, 0);

      $display("[TB] randomized games");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulse_reset("rnd_rst");
         end else begin
            clr = m_done ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            v   = ($urandom_range(0, 3) != 0);
            r   = ($urandom_range(0, 9) == 9) ? 3 : int'($urandom_range(0, 2));
            sa  = int'($urandom_range(0, 255));
            sb  = int'($urandom_range(0, 255));
            step("rnd", v, r, sa, sb, clr);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
